ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Parametrised instruction-fetch stage for the single-issue RISC-V core. It owns the program counter and issues word reads to a synchronous instruction ROM with fixed latency. Returned words are buffered in a small queue and handed to decode through a valid/ready handshake. It adds four things the fixed-width PC/ROM pairing lacks: redirects that flush wrong-path fetches, back-pressure, an ecall halt/resume FSM, and misaligned-target faulting.

## Interface
- XLEN, 32, PC and instruction width.
- RESET_VEC, 32'h0000_0000, PC loaded on reset.
- IMEM_AW, 14, word-address width to ROM.
- MEM_LAT, 1, ROM read latency in cycles; legal range 1..3.
- FQ_DEPTH, 4, fetch-queue entries; power of 2, must be ≥2.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  jump/branch taken this cycle.
- redirect_pc  in  XLEN  target address.
- halt_req  in  1  ecall seen; stop fetching.
- resume  in  1  leave HALTED.
- imem_en  out  1  ROM read strobe.
- imem_addr  out  IMEM_AW  equals pc[IMEM_AW+1:2].
- imem_rdata  in  XLEN  ROM data, valid MEM_LAT cycles after the strobe.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts.
- inst  out  XLEN  queue-head instruction.
- inst_pc  out  XLEN  PC of queue head.
- halted  out  1  in HALTED state.
- fault  out  1  misaligned redirect captured; sticky until reset.

## Operation
- FSM states are RUN, DRAIN, HALTED and FAULT. Reset enters RUN.
- **RUN**
  - Issue rule: issue when `count + inflight - pop < FQ_DEPTH`.
  - `pop = inst_valid & inst_ready`.
  - On issue: `imem_en=1`, the current pc is tagged into an MEM_LAT-deep in-flight shift register, and `pc <= pc+4` (mod 2^XLEN).
- **halt_req in RUN**: go to DRAIN.
  - Issue is suppressed; in-flight words still land and the queue drains to decode.
  - When inflight=0 and count=0, go to HALTED.
- **HALTED**
  - No issue; `halted=1`.
  - resume → RUN; issue restarts at the held pc.
- **redirect_valid**, in any state except FAULT:
  - Queue is flushed and in-flight tags are invalidated; their data is dropped on return.
  - `pc <= redirect_pc`.
  - No issue occurs in the redirect cycle.
  - The state is unchanged, except DRAIN with queue now empty goes to HALTED.
- **Misaligned target**: if redirect_pc[1:0] != 0, enter FAULT instead.
  - FAULT means flush, `fault=1`, `halted=1`, and no issue until reset.
  - pc holds the faulting target.
- **Priority**: rst_n > redirect_valid > halt_req > resume.
  - halt_req and resume together in HALTED: stay HALTED.
- **Queue full**: issue stalls; pc holds; imem_en=0.
- **Queue empty**: inst_valid=0; inst and inst_pc hold the last value.
- **Pop and push in the same cycle with the queue full**: both take effect; count is unchanged.

## Timing
- Reset values:
  - pc = RESET_VEC.
  - imem_en=0 during reset. imem_addr = RESET_VEC[IMEM_AW+1:2].
  - inst_valid=0; inst=0; inst_pc=0.
  - halted=0; fault=0.
  - Queue and in-flight tags cleared.
- First issue occurs in the first cycle after rst_n deasserts (cycle 0).
- Issue in cycle n → data captured at the end of cycle n+MEM_LAT → inst_valid in cycle n+MEM_LAT+1.
- First instruction valid: cycle MEM_LAT+1 after reset release.
- Throughput is one instruction per cycle with inst_ready held high, provided FQ_DEPTH ≥ MEM_LAT+1.
- Redirect in cycle r:
  - inst_valid=0 in cycle r+1.
  - Target issued in r+1; first target instruction valid in r+MEM_LAT+2.
  - A pop in cycle r is a completed handshake; decode owns discarding it.
- halted rises in the cycle after the last queue entry pops.
- Async reset mid-fetch clears everything immediately; no ROM data is accepted after reset.

## Structure
- Package ifetch_pkg holds:
  - fetch_state_e enum {RUN, DRAIN, HALTED, FAULT};
  - INST_NOP = 32'h0000_0013, which drives inst while empty in simulation builds only;
  - default XLEN.
- Sub-module fetch_fifo:
  - parametrised width (2·XLEN) and depth, synchronous flush;
  - outputs count, full, empty.
- The in-flight tag pipeline, FSM and PC stay in ifetch_unit.

## Test plan
- **Reset then free-run**: ROM returns the word index; MEM_LAT=1; inst_ready=1. Required: inst_pc = 0,4,8,… from cycle 2, one per cycle, no gaps.
- **Back-pressure**: inst_ready=0 for 10 cycles from cycle 3. Required: count saturates at 4; imem_en=0 while full; no lost or duplicated PCs after release.
- **Redirect**: redirect to 0x100 in cycle 5 with 2 fetches in flight. Required: inst_valid=0 in cycle 6; the next delivered inst_pc is 0x100 at cycle 8; no stale 0x1x words appear.
- **Halt/resume**: halt_req at cycle 4. Required: remaining queued words are delivered; halted=1 after the last pop; resume restarts at the next sequential pc.
- **Misaligned redirect**: redirect_pc=0x102. Required: fault=1 and halted=1 next cycle; imem_en stays 0; a later redirect is ignored.
- **MEM_LAT=3, FQ_DEPTH=4**: sustained one instruction per cycle; redirect and wrap at pc=0xFFFF_FFFC → 0x0 are correct.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_e - fetch control FSM states
//   INST_NOP      - canonical RISC-V nop (addi x0,x0,0), shown on an empty
//                   queue only when IFETCH_SIM_NOP is defined
//   XLEN_DEFAULT  - default PC / instruction width
package ifetch_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular queue with a synchronous flush.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             empties the queue at the next edge (wins over push)
//   push, wdata       write request and data (dropped when full without a pop)
//   pop               read request (ignored when empty)
//   rdata             head entry, valid while !empty
//   count/full/empty  occupancy
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full queue is legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count alone decides which
    // entries are meaningful, so resetting it would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage owning the PC, issuing word reads to a fixed-
// latency ROM, buffering returned words and handing them to decode.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   redirect_valid, redirect_pc     taken branch/jump and its target
//   halt_req, resume                ecall halt / restart
//   imem_en, imem_addr, imem_rdata  ROM read strobe, word address, data
//   inst_valid, inst_ready          decode handshake
//   inst, inst_pc                   queue-head word and its PC
//   halted, fault                   HALTED/FAULT status (fault is sticky)
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IMEM_AW   = 14,
    parameter int              MEM_LAT   = 1,
    parameter int              FQ_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               halt_req,
    input  logic               resume,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [XLEN-1:0]    inst,
    output logic [XLEN-1:0]    inst_pc,
    output logic               halted,
    output logic               fault
);

    // Wide enough for count + in-flight, which never exceeds FQ_DEPTH + 3.
    localparam int CW = $clog2(FQ_DEPTH) + 2;

    fetch_state_e            state, state_d;
    logic [XLEN-1:0]         pc;
    logic [MEM_LAT-1:0]      vld;
    logic [XLEN-1:0]         tag_pc [MEM_LAT];
    logic [2*XLEN-1:0]       head, last_head;
    logic [$clog2(FQ_DEPTH):0] fifo_count;
    logic                    fifo_full, fifo_empty;
    logic                    redirect_ok, pop, push, issue, room, pending, drain_done;

    assign redirect_ok = redirect_valid & (state != FAULT);
    assign pop         = inst_valid & inst_ready;
    // The word landing in a redirect cycle belongs to the wrong path.
    assign push        = vld[MEM_LAT-1] & ~redirect_ok;

    assign room = ((CW'(fifo_count) + CW'($countones(vld))) < (CW'(FQ_DEPTH) + CW'(pop)))
                  & (~fifo_full | pop);

    // Tags still travelling after this edge (the last stage lands now).
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < MEM_LAT - 1; i++) pending = pending | vld[i];
    end

    assign drain_done = ~pending &
                        (((fifo_count == '0) & ~push) |
                         ((fifo_count == 1) & pop & ~push));

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state;
        issue   = 1'b0;
        if (redirect_ok) begin
            if (|redirect_pc[1:0]) state_d = FAULT;
            else if (state == DRAIN) state_d = HALTED;
        end else begin
            case (state)
                RUN:     if (halt_req) state_d = DRAIN; else issue = room;
                DRAIN:   if (drain_done) state_d = HALTED;
                HALTED:  if (resume && !halt_req) state_d = RUN;
                default: state_d = state;
            endcase
        end
    end

    // Reset gates the strobe directly so no read leaves while rst_n is low.
    assign imem_en   = issue & rst_n;
    assign imem_addr = pc[IMEM_AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_VEC;
            vld   <= '0;
        end else begin
            state <= state_d;
            if (redirect_ok)  pc <= redirect_pc;
            else if (imem_en) pc <= pc + XLEN'(4);
            if (redirect_ok) begin
                vld <= '0;
            end else begin
                vld[0] <= imem_en;
                for (int i = 1; i < MEM_LAT; i++) vld[i] <= vld[i-1];
            end
        end
    end

    // Tags travel unconditionally; vld decides whether a stage is live.
    always_ff @(posedge clk) begin
        tag_pc[0] <= pc;
        for (int i = 1; i < MEM_LAT; i++) tag_pc[i] <= tag_pc[i-1];
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_ok),
        .push  (push),
        .wdata ({tag_pc[MEM_LAT-1], imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Remembers the last head shown so an empty queue keeps presenting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           last_head <= '0;
        else if (!fifo_empty) last_head <= head;
    end

    assign inst_valid = ~fifo_empty;
    assign inst_pc    = fifo_empty ? last_head[2*XLEN-1:XLEN] : head[2*XLEN-1:XLEN];
`ifdef IFETCH_SIM_NOP
    assign inst       = fifo_empty ? XLEN'(INST_NOP) : head[XLEN-1:0];
`else
    assign inst       = fifo_empty ? last_head[XLEN-1:0] : head[XLEN-1:0];
`endif

    assign halted = (state == HALTED) | (state == FAULT);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit. Two instances share clock
// and reset: u_dut1 (MEM_LAT=1, reset vector 0) and u_dut3 (MEM_LAT=3,
// reset vector 0xFFFF_FFF0 so the PC wraps). Each ROM returns the word index.
// Cycle k after reset release is observed 1 time unit after the k-th negedge.
module tb_ifetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        r1_valid, halt1, resume1, en1, iv1, ir1, halted1, fault1;
    logic [31:0] r1_pc, rdata1, inst1, ipc1;
    logic [13:0] addr1;
    logic        r3_valid, halt3, resume3, en3, iv3, ir3, halted3, fault3;
    logic [31:0] r3_pc, rdata3, inst3, ipc3;
    logic [13:0] addr3;
    logic [31:0] p3a, p3b;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pops;
    logic [31:0] exp_pc;

    ifetch_unit #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .redirect_valid(r1_valid), .redirect_pc(r1_pc),
        .halt_req(halt1), .resume(resume1), .imem_en(en1), .imem_addr(addr1),
        .imem_rdata(rdata1), .inst_valid(iv1), .inst_ready(ir1), .inst(inst1),
        .inst_pc(ipc1), .halted(halted1), .fault(fault1)
    );

    ifetch_unit #(.MEM_LAT(3), .RESET_VEC(32'hFFFF_FFF0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .redirect_valid(r3_valid), .redirect_pc(r3_pc),
        .halt_req(halt3), .resume(resume3), .imem_en(en3), .imem_addr(addr3),
        .imem_rdata(rdata3), .inst_valid(iv3), .inst_ready(ir3), .inst(inst3),
        .inst_pc(ipc3), .halted(halted3), .fault(fault3)
    );

    // ROM models: word index comes back MEM_LAT cycles after the strobe.
    always @(posedge clk) rdata1 <= en1 ? {18'b0, addr1} : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        p3a    <= en3 ? {18'b0, addr3} : 32'hDEAD_BEEF;
        p3b    <= p3a;
        rdata3 <= p3b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        r1_valid = 0; r1_pc = '0; halt1 = 0; resume1 = 0; ir1 = 1;
        r3_valid = 0; r3_pc = '0; halt3 = 0; resume3 = 0; ir3 = 1;
    endtask

    // Scoreboards: every handshake must carry the next expected PC and word.
    task automatic mon1();
        if (iv1 && ir1) begin
            check("pc1", ipc1, exp_pc);
            check("inst1", inst1, {18'b0, exp_pc[15:2]});
            exp_pc += 32'd4;
            pops++;
        end
    endtask

    task automatic mon3();
        if (iv3 && ir3) begin
            check("pc3", ipc3, exp_pc);
            check("inst3", inst3, {18'b0, exp_pc[15:2]});
            exp_pc += 32'd4;
            pops++;
        end
    endtask

    // Asserts reset mid-activity, checks reset values, releases on a negedge.
    task automatic do_reset(input logic [31:0] start_pc);
        idle();
        rst_n = 1'b0;
        #1;
        check("rst_en1", en1, 1'b0);
        check("rst_addr1", addr1, 14'h0);
        check("rst_valid1", iv1, 1'b0);
        check("rst_inst1", inst1, 32'h0);
        check("rst_ipc1", ipc1, 32'h0);
        check("rst_halted1", halted1, 1'b0);
        check("rst_fault1", fault1, 1'b0);
        check("rst_en3", en3, 1'b0);
        check("rst_addr3", addr3, 14'h3FFC);
        check("rst_valid3", iv3, 1'b0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = start_pc;
        pops   = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);

        // Free-run, MEM_LAT=1: first valid in cycle 2, then one per cycle.
        do_reset(32'h0);
        for (int k = 0; k < 14; k++) begin
            idle();
            #1;
            if (k == 0) check("t1_en0", en1, 1'b1);
            if (k == 1) check("t1_addr1", addr1, 14'd1);
            check("t1_valid", iv1, (k >= 2));
            mon1();
            @(negedge clk);
        end
        check("t1_pops", pops, 12);

        // Back-pressure: ready low in cycles 3..12.
        do_reset(32'h0);
        for (int k = 0; k < 25; k++) begin
            idle();
            ir1 = !(k >= 3 && k <= 12);
            #1;
            if (k == 4) check("t2_en_last", en1, 1'b1);
            if (k >= 5 && k <= 12) check("t2_en_full", en1, 1'b0);
            if (k >= 6 && k <= 12) begin
                check("t2_hold_valid", iv1, 1'b1);
                check("t2_hold_pc", ipc1, 32'h4);
            end
            mon1();
            @(negedge clk);
        end
        check("t2_pops", pops, 13);

        // Redirect to 0x100 in cycle 5.
        do_reset(32'h0);
        for (int k = 0; k < 13; k++) begin
            idle();
            r1_valid = (k == 5);
            r1_pc    = 32'h100;
            #1;
            if (k == 5) check("t3_en_redir", en1, 1'b0);
            if (k == 6) begin
                check("t3_valid6", iv1, 1'b0);
                check("t3_en6", en1, 1'b1);
                check("t3_addr6", addr1, 14'h40);
            end
            if (k == 7) check("t3_valid7", iv1, 1'b0);
            if (k == 8) check("t3_valid8", iv1, 1'b1);
            mon1();
            if (k == 5) exp_pc = 32'h100;
            @(negedge clk);
        end
        check("t3_pops", pops, 9);

        // Halt at cycle 4, halt+resume together at 7, resume at 8.
        do_reset(32'h0);
        for (int k = 0; k < 15; k++) begin
            idle();
            halt1   = (k == 4) || (k == 7);
            resume1 = (k == 7) || (k == 8);
            #1;
            if (k >= 4 && k <= 8) check("t4_en_off", en1, 1'b0);
            if (k == 5) check("t4_halted5", halted1, 1'b0);
            if (k == 6 || k == 8) check("t4_halted", halted1, 1'b1);
            if (k == 6 || k == 7) check("t4_valid_off", iv1, 1'b0);
            if (k == 9) begin
                check("t4_halted9", halted1, 1'b0);
                check("t4_en9", en1, 1'b1);
                check("t4_addr9", addr1, 14'd4);
            end
            mon1();
            @(negedge clk);
        end
        check("t4_pops", pops, 8);

        // Misaligned redirect in cycle 5, aligned one (ignored) in cycle 8.
        do_reset(32'h0);
        for (int k = 0; k < 13; k++) begin
            idle();
            r1_valid = (k == 5) || (k == 8);
            r1_pc    = (k == 5) ? 32'h102 : 32'h200;
            #1;
            if (k == 5) check("t5_fault5", fault1, 1'b0);
            if (k >= 6) begin
                check("t5_fault", fault1, 1'b1);
                check("t5_halted", halted1, 1'b1);
                check("t5_en", en1, 1'b0);
                check("t5_valid", iv1, 1'b0);
            end
            if (k == 12) check("t5_addr_hold", addr1, 14'h40);
            mon1();
            @(negedge clk);
        end
        check("t5_pops", pops, 4);

        // MEM_LAT=3: wrap past 0xFFFF_FFFC, redirect to 0x300 in cycle 12.
        do_reset(32'hFFFF_FFF0);
        for (int k = 0; k < 21; k++) begin
            idle();
            r3_valid = (k == 12);
            r3_pc    = 32'h300;
            #1;
            check("t6_valid", iv3, (k >= 4 && k <= 12) || (k >= 17));
            if (k == 12) check("t6_en_redir", en3, 1'b0);
            if (k == 13) begin
                check("t6_en13", en3, 1'b1);
                check("t6_addr13", addr3, 14'hC0);
            end
            mon3();
            if (k == 12) exp_pc = 32'h300;
            @(negedge clk);
        end
        check("t6_pops", pops, 13);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
